// File: rtl/btn_action_conditioner.sv
// Push-button front end: synchronise, debounce, classify short/long presses and
// stretch each press event into a fixed-length beep-enable window.
module btn_action_conditioner #(
    parameter bit          BTN_ACTIVE_LOW    = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
    parameter int unsigned LONG_PRESS_CYCLES = 250_000_000,
    parameter int unsigned BEEP_CYCLES       = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_long,
    output logic btn_action
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);
    localparam int BEEP_W = $clog2(BEEP_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [BEEP_W-1:0] BEEP_FULL = BEEP_W'(BEEP_CYCLES);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] PRESSED   = 2'd1;
    localparam logic [1:0] LONG_HELD = 2'd2;

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              level_q, level_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [1:0]        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              press_q, press_d;
    logic              long_q, long_d;
    logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;
    logic              action_q, action_d;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        sync1_d    = btn_raw ^ BTN_ACTIVE_LOW;
        sync2_d    = sync1_q;

        level_d    = level_q;
        db_cnt_d   = '0;
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        press_d    = 1'b0;
        long_d     = 1'b0;
        beep_cnt_d = beep_cnt_q;

        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (level_q) begin
                    press_d    = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = PRESSED;
                end
            end
            PRESSED: begin
                // Release is checked first so it wins over a coincident threshold.
                if (!level_q) begin
                    state_d = IDLE;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    long_d  = 1'b1;
                    state_d = LONG_HELD;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            LONG_HELD: begin
                if (!level_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (press_q || long_q) begin
            beep_cnt_d = BEEP_FULL;
        end else if (beep_cnt_q != '0) begin
            beep_cnt_d = beep_cnt_q - 1'b1;
        end

        // Registered from the next count so the window starts one cycle after the pulse.
        action_d = (beep_cnt_d != '0);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            level_q    <= 1'b0;
            db_cnt_q   <= '0;
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            press_q    <= 1'b0;
            long_q     <= 1'b0;
            beep_cnt_q <= '0;
            action_q   <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            level_q    <= level_d;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            press_q    <= press_d;
            long_q     <= long_d;
            beep_cnt_q <= beep_cnt_d;
            action_q   <= action_d;
        end
    end

    assign btn_level  = level_q;
    assign btn_press  = press_q;
    assign btn_long   = long_q;
    assign btn_action = action_q;

endmodule

// File: tb/tb_btn_action_conditioner.sv
// Directed bench for btn_action_conditioner: a vector table for reset and a clean
// short press, plus hand-written sequences for bounce, long press, retrigger, reset.
module tb_btn_action_conditioner;

    logic clk = 1'b0;
    logic rst;
    logic btn_raw;
    logic btn_level, btn_press, btn_long, btn_action;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    btn_action_conditioner #(
        .BTN_ACTIVE_LOW   (1'b1),
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(20),
        .BEEP_CYCLES      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_press (btn_press),
        .btn_long  (btn_long),
        .btn_action(btn_action)
    );

    // Output bundle order: {level, press, long, action}.
    typedef struct {
        logic       rst;
        logic       raw;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[23];

    function automatic logic [3:0] outs();
        return {btn_level, btn_press, btn_long, btn_action};
    endfunction

    function automatic logic [3:0] pack(input bit lvl, input bit prs, input bit lng, input bit act);
        return {lvl, prs, lng, act};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got {lvl,prs,lng,act}=%b expected %b", name, act, exp);
        end
    endtask

    // One clock edge, then settle before sampling and driving the next inputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic r, input logic raw);
        rst     = r;
        btn_raw = raw;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, 1'b1);
    endtask

    initial begin
        rst     = 1'b1;
        btn_raw = 1'b1;

        // Reset: three cycles, all outputs cleared.
        for (int i = 0; i < 3; i++) vecs[i] = '{1'b1, 1'b1, 4'b0000};
        // Short press, entry k checks cycle T+k+1: raw low k=0..9.
        vecs[3]  = '{1'b0, 1'b0, 4'b0000};
        vecs[4]  = '{1'b0, 1'b0, 4'b0000};
        vecs[5]  = '{1'b0, 1'b0, 4'b0000};
        vecs[6]  = '{1'b0, 1'b0, 4'b0000};
        vecs[7]  = '{1'b0, 1'b0, 4'b0000};
        vecs[8]  = '{1'b0, 1'b0, 4'b1000};
        vecs[9]  = '{1'b0, 1'b0, 4'b1100};
        vecs[10] = '{1'b0, 1'b0, 4'b1001};
        vecs[11] = '{1'b0, 1'b0, 4'b1001};
        vecs[12] = '{1'b0, 1'b0, 4'b1001};
        vecs[13] = '{1'b0, 1'b1, 4'b1001};
        vecs[14] = '{1'b0, 1'b1, 4'b1001};
        vecs[15] = '{1'b0, 1'b1, 4'b1001};
        vecs[16] = '{1'b0, 1'b1, 4'b1001};
        vecs[17] = '{1'b0, 1'b1, 4'b1001};
        vecs[18] = '{1'b0, 1'b1, 4'b0000};
        vecs[19] = '{1'b0, 1'b1, 4'b0000};
        vecs[20] = '{1'b0, 1'b1, 4'b0000};
        vecs[21] = '{1'b0, 1'b1, 4'b0000};
        vecs[22] = '{1'b0, 1'b1, 4'b0000};

        for (int i = 0; i < 3; i++) begin
            apply(vecs[i].rst, vecs[i].raw);
            check($sformatf("reset_vec%0d", i), outs(), vecs[i].exp);
        end

        for (int i = 0; i < 50; i++) begin
            apply(1'b0, 1'b1);
            check($sformatf("idle_c%0d", i), outs(), 4'b0000);
        end

        for (int i = 3; i < 23; i++) begin
            apply(vecs[i].rst, vecs[i].raw);
            check($sformatf("short_k%0d", i - 3), outs(), vecs[i].exp);
        end
        idle(5);

        // Bounce: 2-cycle runs never reach the 4-cycle debounce threshold.
        for (int k = 0; k < 28; k++) begin
            apply(1'b0, (k < 20) ? logic'((k / 2) % 2) : 1'b1);
            check($sformatf("bounce_k%0d", k), outs(), 4'b0000);
        end
        idle(5);

        // Long press: press at k=6, long at k=26, two beep windows.
        for (int k = 0; k < 40; k++) begin
            apply(1'b0, 1'b0);
            check($sformatf("long_k%0d", k), outs(),
                  pack(k >= 5, k == 6, k == 26, (k >= 7 && k <= 14) || (k >= 27 && k <= 34)));
        end
        for (int k = 0; k < 20; k++) begin
            apply(1'b0, 1'b1);
            check($sformatf("long_rel_k%0d", k), outs() & 4'b0110, 4'b0000);
        end
        check("long_rel_final", outs(), 4'b0000);
        idle(5);

        // Retrigger: presses 8 cycles apart (tightest spacing the debouncer allows)
        // reload the beep on its last cycle, giving one unbroken window.
        for (int k = 0; k < 32; k++) begin
            apply(1'b0, ((k >= 4 && k <= 7) || k >= 12) ? 1'b1 : 1'b0);
            check($sformatf("retrig_k%0d", k), outs(),
                  pack((k >= 5 && k <= 8) || (k >= 13 && k <= 16), k == 6 || k == 14,
                       1'b0, k >= 7 && k <= 22));
        end
        idle(5);

        // Reset mid-beep with the button still held: fresh press 7 cycles after release of rst.
        for (int k = 0; k < 30; k++) begin
            logic [3:0] exp;
            if (k < 10)       exp = pack(k >= 5, k == 6, 1'b0, k >= 7);
            else if (k < 16)  exp = 4'b0000;
            else              exp = pack(1'b1, k == 17, 1'b0, k >= 18 && k <= 25);
            apply(k == 10, 1'b0);
            check($sformatf("rst_mid_k%0d", k), outs(), exp);
        end
        idle(20);
        check("rst_mid_final", outs(), 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
